ex_muldiv_unit: RTL
===================

// Module: ex_muldiv_unit
// PURPOSE
//  Iterative multiply/divide unit in the EX stage, fed directly by the ID/EX register
//  (operands ReadData1_EX/ReadData2_EX plus a decoded op). Owns architectural HI/LO.
//  Executes MULT/MULTU/DIV/DIVU in WIDTH+2 cycles and stalls the pipeline while busy.
//  Also executes MTHI/MTLO. Exposes HI/LO to the MFHI/MFLO path.
// PARAMETERS
//  WIDTH  32  operand/result width; one shift-add or shift-subtract step per cycle
// PORTS
//  Clk       in   1      pipeline clock, all state updates on rising edge
//  Reset_n   in   1      asynchronous, active-low reset
//  Start_EX  in   1      EX holds a valid muldiv/MTHI/MTLO instruction
//  Op_EX     in   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op
//  A_EX      in   WIDTH  rs operand (post-forwarding)
//  B_EX      in   WIDTH  rt operand (post-forwarding)
//  Flush     in   1      EX instruction is squashed; Start_EX ignored this cycle
//  Stall     out  1      freeze PC, IF/ID, ID/EX; bubble into EX/MEM (combinational)
//  Busy      out  1      state != IDLE (registered)
//  Done      out  1      one-cycle pulse in FIX state
//  Hi        out  WIDTH  HI register
//  Lo        out  WIDTH  LO register
// BEHAVIOUR
//  Reset (Reset_n=0, any time, incl. mid-op): state=IDLE, counter=0, Hi=Lo=0,
//   Busy=Done=0. Stall=0 until Reset_n rises. No partial result is written.
//  accept = Start_EX & ~Flush & (state==IDLE). Op 110/111 is a no-op: no effect, no stall.
//  FSM IDLE -> CALC -> FIX -> IDLE:
//   IDLE: accept & MTHI: Hi<=A_EX at the edge. accept & MTLO: Lo<=A_EX. No stall.
//         accept & mul/div op: latch |A|,|B| (raw operands if unsigned op) and result signs.
//         Clear accumulator, counter<=WIDTH-1, go to CALC.
//   CALC: one radix-2 step per cycle. Mul: shift-add into a 2*WIDTH product.
//         Div: restoring shift-subtract. counter==0 -> FIX, else counter--.
//         Inputs are ignored.
//   FIX:  apply signs; at the edge leaving FIX write Hi/Lo, go to IDLE; Done=1 in this cycle.
//         Start_EX here belongs to the same, completing instruction and is ignored.
//  Stall = (state==IDLE & accept & op is mul/div) | (state==CALC).
//   Stall is 0 in FIX, so the instruction leaves EX on the FIX edge.
//   Total stall = WIDTH+1 cycles. Hi/Lo are valid from the cycle after FIX.
//  Back-to-back mul/div: the second op is accepted in the IDLE cycle after FIX.
//  MFHI/MFLO directly after a mul/div reads the new values without an extra stall.
//  Results:
//   MULT/MULTU: {Hi,Lo} = 2*WIDTH-bit product. Signed product is negated iff signs differ.
//   DIV/DIVU:   Lo = quotient, Hi = remainder. Signed: quotient truncates toward zero,
//               remainder takes the sign of the dividend.
//   Divide by zero (B==0), signed or unsigned: Lo = all ones, Hi = A.
//               Full latency, no exception.
//   Signed overflow 0x80000000 / -1: Lo = 0x80000000, Hi = 0.
//  Flush asserted with Start_EX in IDLE: nothing starts, no stall.
//  Flush during CALC/FIX: ignored; the op in flight is older than any flush source.
//  Widths: all internal arithmetic is unsigned on magnitudes. Adder is WIDTH+1 bits
//   (carry/borrow). Counter is clog2(WIDTH) bits.
// TESTING
//  MULT A=FFFFFFFF B=00000002 -> Stall high 33 cycles, Done pulse, Hi=FFFFFFFF Lo=FFFFFFFE
//  MULTU same operands -> Hi=00000001 Lo=FFFFFFFE. Back-to-back second op accepted on next IDLE.
//  DIV A=FFFFFFF9(-7) B=2 -> Lo=FFFFFFFD Hi=FFFFFFFF. DIVU 7/2 -> Lo=3 Hi=1.
//  DIVU A=12345678 B=0 -> Lo=FFFFFFFF Hi=12345678. DIV 80000000/FFFFFFFF -> Lo=80000000 Hi=0.
//  MTHI A=AAAA5555 -> Hi updated next edge, Stall=0. Start_EX+Flush with MULT -> no stall, Hi/Lo unchanged.
//  Reset_n low at CALC cycle 10 -> immediate IDLE, Stall=0, Hi=Lo=0. A new MULT afterwards completes correctly.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit
//   Iterative multiply/divide unit living in the EX stage. Owns the
//   architectural HI/LO registers. MULT/MULTU/DIV/DIVU take WIDTH+2 cycles
//   (IDLE accept, WIDTH radix-2 steps in CALC, sign fix-up in FIX) and hold
//   the pipeline through Stall. MTHI/MTLO write HI/LO in a single cycle.
//
// Ports
//   Clk       pipeline clock, rising edge
//   Reset_n   asynchronous active-low reset
//   Start_EX  EX holds a valid muldiv/MTHI/MTLO instruction
//   Op_EX     000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, else no-op
//   A_EX      rs operand (post-forwarding)
//   B_EX      rt operand (post-forwarding)
//   Flush     EX instruction squashed; only honoured when a new op would start
//   Stall     freeze front end, bubble into EX/MEM (combinational)
//   Busy      unit not idle (registered)
//   Done      one-cycle pulse while in FIX (registered)
//   Hi, Lo    architectural HI/LO registers
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start_EX,
  input  logic [2:0]       Op_EX,
  input  logic [WIDTH-1:0] A_EX,
  input  logic [WIDTH-1:0] B_EX,
  input  logic             Flush,
  output logic             Stall,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  // Two's complement negation at operand width.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return (~x) + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Two's complement negation at product width.
  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
    return (~x) + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // acc: upper product half (mul) / partial remainder (div)
  // wrk: multiplier shifting out, low product half shifting in (mul)
  //      dividend shifting out, quotient shifting in (div)
  // opnd: |multiplicand| (mul) / |divisor| (div)
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] wrk_q, wrk_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             is_div_q, is_div_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic             divz_q, divz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, done_q;

  logic             accept_s;
  logic             is_md_s;
  logic             sgn_op_s;
  logic             a_neg_s, b_neg_s;
  logic [WIDTH-1:0] a_mag_s, b_mag_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   shl_s;
  logic [WIDTH:0]   diff_s;
  logic             ge_s;
  logic [2*WIDTH-1:0] prod_s;

  assign accept_s = Start_EX & ~Flush & (state_q == S_IDLE);
  assign is_md_s  = ~Op_EX[2];
  assign sgn_op_s = ~Op_EX[0];

  // Stall is forced low while reset is held so the front end never freezes in reset.
  assign Stall = Reset_n & ((accept_s & is_md_s) | (state_q == S_CALC));
  assign Busy  = busy_q;
  assign Done  = done_q;
  assign Hi    = hi_q;
  assign Lo    = lo_q;

  // State, datapath and architectural HI/LO registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= CNT_ZERO;
      acc_q    <= '0;
      wrk_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      divz_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      wrk_q    <= wrk_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      divz_q   <= divz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= (state_d != S_IDLE);
      done_q   <= (state_d == S_FIX);
    end
  end

  // Next-state and datapath logic for the IDLE -> CALC -> FIX sequence.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    wrk_d    = wrk_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    divz_d   = divz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    a_neg_s = sgn_op_s & A_EX[WIDTH-1];
    b_neg_s = sgn_op_s & B_EX[WIDTH-1];
    a_mag_s = a_neg_s ? neg_w(A_EX) : A_EX;
    b_mag_s = b_neg_s ? neg_w(B_EX) : B_EX;

    // Multiply step: conditional add of the multiplicand, then shift right.
    sum_s  = wrk_q[0] ? ({1'b0, acc_q} + {1'b0, opnd_q}) : {1'b0, acc_q};
    // Divide step: shift next dividend bit in, trial-subtract the divisor.
    // With remainder < divisor the borrow lands in diff_s[WIDTH]. For a zero
    // divisor both paths keep the shifted value, so the remainder ends at |A|.
    shl_s  = {acc_q, wrk_q[WIDTH-1]};
    diff_s = shl_s - {1'b0, opnd_q};
    ge_s   = ~diff_s[WIDTH];
    prod_s = {acc_q, wrk_q};

    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          case (Op_EX)
            3'b000, 3'b001, 3'b010, 3'b011: begin
              is_div_d = Op_EX[1];
              neg_a_d  = a_neg_s;
              neg_b_d  = b_neg_s;
              divz_d   = Op_EX[1] & (B_EX == '0);
              acc_d    = '0;
              wrk_d    = Op_EX[1] ? a_mag_s : b_mag_s;
              opnd_d   = Op_EX[1] ? b_mag_s : a_mag_s;
              cnt_d    = CNT_INIT;
              state_d  = S_CALC;
            end
            3'b100: begin
              hi_d = A_EX;
            end
            3'b101: begin
              lo_d = A_EX;
            end
            default: begin
              state_d = S_IDLE;
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end

      S_CALC: begin
        if (is_div_q) begin
          acc_d = ge_s ? diff_s[WIDTH-1:0] : shl_s[WIDTH-1:0];
          wrk_d = {wrk_q[WIDTH-2:0], ge_s};
        end else begin
          acc_d = sum_s[WIDTH:1];
          wrk_d = {sum_s[0], wrk_q[WIDTH-1:1]};
        end
        if (cnt_q == CNT_ZERO) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      S_FIX: begin
        if (is_div_q) begin
          // Quotient sign = sign(A) xor sign(B); remainder follows the dividend.
          if (divz_q) begin
            lo_d = '1;
          end else begin
            lo_d = (neg_a_q ^ neg_b_q) ? neg_w(wrk_q) : wrk_q;
          end
          hi_d = neg_a_q ? neg_w(acc_q) : acc_q;
        end else begin
          if (neg_a_q ^ neg_b_q) begin
            {hi_d, lo_d} = neg_2w(prod_s);
          end else begin
            {hi_d, lo_d} = prod_s;
          end
        end
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
